// File: rtl/mu_seq_if.sv
// mu_seq_if: bundle of all handshake and datapath signals around mu_seq.
//
// Groups:
//   req_* : decode -> sequencer request channel (valid/ready)
//   flush : kill of any pending or in-flight request
//   mu_*  : operand/control lines to the multiply unit and its result
//   rsp_* : sequencer -> writeback response channel (valid/ready)
//   busy  : stall indication to the core
//
// Modports:
//   slave  : the sequencer side (mu_seq)
//   master : the surrounding core/datapath side
interface mu_seq_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic [1:0]      req_mulctl;
    logic [4:0]      req_rd;
    logic            flush;
    logic [XLEN-1:0] mu_a;
    logic [XLEN-1:0] mu_b;
    logic [1:0]      mu_mulctl;
    logic [XLEN-1:0] mu_mulres;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic [4:0]      rsp_rd;
    logic            busy;

    modport slave (
        input  req_valid, req_a, req_b, req_mulctl, req_rd, flush,
               mu_mulres, rsp_ready,
        output req_ready, mu_a, mu_b, mu_mulctl,
               rsp_valid, rsp_data, rsp_rd, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_mulctl, req_rd, flush,
               mu_mulres, rsp_ready,
        input  req_ready, mu_a, mu_b, mu_mulctl,
               rsp_valid, rsp_data, rsp_rd, busy
    );
endinterface

// File: rtl/mu_seq.sv
// mu_seq: issue/handshake sequencer in front of the fixed-latency multiply
// unit mu. Accepts one RV32M multiply request, holds operands and mulctl
// stable on mu's inputs for MU_LAT cycles, captures mu's result and offers
// it to writeback together with the destination tag.
//
// Parameters:
//   MU_LAT : cycles from stable mu inputs to valid mulres (>= 1)
//   XLEN   : operand/result width
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : mu_seq_if.slave (request, flush, mu, response, busy)
//   dbg_state : current FSM state (0 IDLE, 1 WAIT, 2 DONE)
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both high. The request side may drop or change
// req_* freely while req_ready is low. The response side holds rsp_valid,
// rsp_data and rsp_rd stable until the transfer, unless a flush kills it.
module mu_seq #(
    parameter int MU_LAT = 4,
    parameter int XLEN   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    mu_seq_if.slave    bus,
    output logic [1:0] dbg_state
);
    localparam int CW = $clog2(MU_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] mu_a_q, mu_b_q, rsp_data_q;
    logic [1:0]      mu_mulctl_q;
    logic [4:0]      rsp_rd_q;
    logic            rsp_valid_q, busy_q;
    logic            req_ready, accept, last_cnt, capture;

    // A new request may enter in DONE only when the current result leaves
    // on the same edge; flush blocks acceptance outright.
    always_comb begin
        req_ready = !bus.flush &&
                    ((state_q == IDLE) || ((state_q == DONE) && bus.rsp_ready));
        accept    = bus.req_valid && req_ready;
        last_cnt  = (state_q == WAIT) && (cnt_q == CW'(1));
        capture   = last_cnt && !bus.flush;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) state_d = WAIT;
                WAIT: if (last_cnt) state_d = DONE;
                DONE: if (bus.rsp_ready) state_d = accept ? WAIT : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // rsp_valid and busy are registered copies of the next-state decode so
    // they line up exactly with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mu_a_q      <= '0;
            mu_b_q      <= '0;
            mu_mulctl_q <= 2'b00;
            rd_q        <= 5'd0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_rd_q    <= 5'd0;
        end else begin
            if (accept) begin
                mu_a_q      <= bus.req_a;
                mu_b_q      <= bus.req_b;
                mu_mulctl_q <= bus.req_mulctl;
                rd_q        <= bus.req_rd;
                cnt_q       <= CW'(MU_LAT);
            end else if ((state_q == WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (capture) begin
                rsp_data_q <= bus.mu_mulres;
                rsp_rd_q   <= rd_q;
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.mu_a      = mu_a_q;
    assign bus.mu_b      = mu_b_q;
    assign bus.mu_mulctl = mu_mulctl_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_rd    = rsp_rd_q;
    assign bus.busy      = busy_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_mu_seq.sv
module tb_mu_seq;
    localparam int MU_LAT = 4;
    localparam int XLEN   = 32;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mu_seq_if #(.XLEN(XLEN)) bus();
    logic [1:0] dbg_state;

    mu_seq #(.MU_LAT(MU_LAT), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // behavioural mu: MU_LAT-1 register stages after the operand registers
    function automatic logic [31:0] mu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] ctl);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (ctl)
            2'b01:   p = sa * sb;
            2'b10:   p = sa * $signed(ub);
            default: p = ua * ub;
        endcase
        return (ctl == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    logic [31:0] pipe0 = '0, pipe1 = '0, pipe2 = '0;
    always @(posedge clk) begin
        pipe0 <= mu_f(bus.mu_a, bus.mu_b, bus.mu_mulctl);
        pipe1 <= pipe0;
        pipe2 <= pipe1;
    end
    assign bus.mu_mulres = pipe2;

    // scoreboard
    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [31:0] cur_a = '0, cur_b = '0;
    logic [1:0]  cur_ctl = 2'b00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (dbg_state == 2'd1) begin
                chk("wait_mu_a", bus.mu_a, cur_a);
                chk("wait_mu_b", bus.mu_b, cur_b);
                chk("wait_mu_ctl", bus.mu_mulctl, cur_ctl);
            end
            if (bus.rsp_valid && !prev_valid) begin
                if (exp_cyc_q.size() == 0) chk("unexpected_rsp", bus.rsp_valid, 0);
                else chk("rsp_latency", cyc, exp_cyc_q.pop_front());
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) chk("unexpected_hs", bus.rsp_valid, 0);
                else chk("rsp_rd_data", {bus.rsp_rd, bus.rsp_data}, exp_q.pop_front());
            end
            prev_valid = bus.rsp_valid;
        end
    end

    // driver tasks
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ctl,
                         input logic [4:0] rd, input logic [31:0] exp, input bit push);
        int n;
        step;
        bus.req_a = a;
        bus.req_b = b;
        bus.req_mulctl = ctl;
        bus.req_rd = rd;
        bus.req_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready && n < 40) begin
            step;
            n++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", bus.req_ready, 1);
        end else begin
            cur_a = a;
            cur_b = b;
            cur_ctl = ctl;
            if (push) begin
                exp_q.push_back({rd, exp});
                exp_cyc_q.push_back(cyc + 1 + MU_LAT);
            end
            step;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while ((bus.busy || bus.rsp_valid) && n < 40) begin
            step;
            n++;
        end
        chk("idle_timeout", bus.busy, 0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_mulctl = 2'b00;
        bus.req_rd = 5'd0;
        bus.flush = 1'b0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) step;
        chk("rst_mu_a", bus.mu_a, 0);
        chk("rst_mu_b", bus.mu_b, 0);
        chk("rst_mu_ctl", bus.mu_mulctl, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_rd", bus.rsp_rd, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_req_ready", bus.req_ready, 1);
        rst_n = 1'b1;

        // reset in the middle of WAIT drops the request
        issue(32'd5, 32'd6, 2'b00, 5'd3, 32'd30, 1'b0);
        step;
        rst_n = 1'b0;
        #1;
        chk("midrst_mu_a", bus.mu_a, 0);
        chk("midrst_mu_b", bus.mu_b, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_state", dbg_state, 0);
        step;
        rst_n = 1'b1;
        #1;
        chk("midrst_req_ready", bus.req_ready, 1);
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        repeat (8) step;

        // basic MUL 3*4
        issue(32'd3, 32'd4, 2'b00, 5'd7, 32'd12, 1'b1);
        wait_idle;

        // all-ones under each mulctl, back to back
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 5'd1, 32'h0000_0001, 1'b1);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 5'd2, 32'h0000_0000, 1'b1);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 5'd3, 32'hFFFF_FFFF, 1'b1);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 5'd4, 32'hFFFF_FFFE, 1'b1);
        wait_idle;

        // writeback stalls 3 cycles in DONE with a new request pending
        bus.rsp_ready = 1'b0;
        issue(32'd7, 32'd6, 2'b00, 5'd9, 32'd42, 1'b1);
        for (int n = 0; n < 40 && !bus.rsp_valid; n++) step;
        chk("hold_reached_done", bus.rsp_valid, 1);
        bus.req_a = 32'h0001_0000;
        bus.req_b = 32'h0001_0000;
        bus.req_mulctl = 2'b11;
        bus.req_rd = 5'd10;
        bus.req_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_req_ready", bus.req_ready, 0);
            chk("hold_rsp_valid", bus.rsp_valid, 1);
            chk("hold_rsp_data", bus.rsp_data, 42);
            chk("hold_rsp_rd", bus.rsp_rd, 9);
            step;
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("hold_release_ready", bus.req_ready, 1);
        cur_a = 32'h0001_0000;
        cur_b = 32'h0001_0000;
        cur_ctl = 2'b11;
        exp_q.push_back({5'd10, 32'h0000_0001});
        exp_cyc_q.push_back(cyc + 1 + MU_LAT);
        step;
        bus.req_valid = 1'b0;
        wait_idle;

        // flush in the second WAIT cycle kills the request
        issue(32'd8, 32'd9, 2'b00, 5'd11, 32'd72, 1'b0);
        step;
        bus.flush = 1'b1;
        step;
        bus.flush = 1'b0;
        chk("flush_busy", bus.busy, 0);
        chk("flush_rsp_valid", bus.rsp_valid, 0);
        chk("flush_state", dbg_state, 0);
        repeat (8) step;
        issue(32'hFFFF_FFFE, 32'd3, 2'b00, 5'd12, 32'hFFFF_FFFA, 1'b1);
        wait_idle;

        // flush together with a request in IDLE
        step;
        bus.flush = 1'b1;
        bus.req_a = 32'd2;
        bus.req_b = 32'd2;
        bus.req_mulctl = 2'b00;
        bus.req_rd = 5'd13;
        bus.req_valid = 1'b1;
        #1;
        chk("flushreq_req_ready", bus.req_ready, 0);
        step;
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        chk("flushreq_state", dbg_state, 0);
        chk("flushreq_busy", bus.busy, 0);
        repeat (8) step;

        chk("scoreboard_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mu_seq.md
# mu_seq

Issue/handshake sequencer directly upstream of the multiply unit `mu` in the datapath. Accepts one RV32M multiply request (MUL/MULH/MULHSU/MULHU) from decode and holds its operands and `mulctl` stable on `mu`'s inputs. Counts `mu`'s fixed pipeline latency, captures `mulres` into a response register and presents it with a valid/ready handshake plus the destination tag. Drives `busy` so the core can stall while a multiply is in flight; supports flush.

## Interface
- `MU_LAT`, default 4: cycles from operands/`mulctl` stable at `mu` inputs until `mulres` is valid; legal ≥1.
- `XLEN`, default 32: operand/result width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset; one clock, asynchronous, active-low.
- `req_valid` in 1: decode presents a multiply request.
- `req_ready` out 1: sequencer can accept this cycle.
- `req_a` in XLEN: rs1 value.
- `req_b` in XLEN: rs2 value.
- `req_mulctl` in 2: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (same encoding as `mu`).
- `req_rd` in 5: destination register tag.
- `flush` in 1: kill any in-flight or pending request.
- `mu_a` out XLEN: to `mu.a`.
- `mu_b` out XLEN: to `mu.b`.
- `mu_mulctl` out 2: to `mu.mulctl`.
- `mu_mulres` in XLEN: from `mu.mulres`.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: writeback consumes result.
- `rsp_data` out XLEN: captured result.
- `rsp_rd` out 5: tag of captured result.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, WAIT, DONE. Reset → IDLE.
- Reset values: `mu_a`=0, `mu_b`=0, `mu_mulctl`=00, `rsp_data`=0, `rsp_rd`=0, `rsp_valid`=0, `busy`=0; counter=0.
- `req_ready` = !flush && (IDLE || (DONE && rsp_ready)). Accept = `req_valid && req_ready`.
- Accept: register `req_a/req_b/req_mulctl` into `mu_a/mu_b/mu_mulctl`, latch `req_rd`, load counter = `MU_LAT`, go to WAIT.
- WAIT: `mu_*` outputs held constant; counter decrements each cycle. On the edge where counter==1: `rsp_data`←`mu_mulres`, `rsp_rd`←latched tag, go to DONE.
- DONE: `rsp_valid`=1, `rsp_data`/`rsp_rd` held until `rsp_valid && rsp_ready`. On handshake: go to WAIT if a new request is accepted on the same edge, else IDLE.
- Flush (any state): next state IDLE, `rsp_valid` low next cycle, no response for the killed request, no accept that cycle. `mu_*` and `rsp_data` keep their values (don't-care).
- Flush has priority over the response handshake and over accept.
- Counter width is clog2(`MU_LAT`+1); no wrap occurs since it is reloaded only on accept.
- Result width is XLEN. `mu_seq` does no arithmetic; it passes `mulres` unmodified.
- Reset asserted mid-operation: immediate return to reset values; the in-flight request is dropped.

## Timing
- Accept at edge k: `mu` inputs valid from cycle k+1. Result captured at edge k+`MU_LAT`; `rsp_valid` high from cycle k+`MU_LAT`+1.
- Request-to-response latency is `MU_LAT`+1 cycles. With `rsp_ready` tied high, back-to-back throughput is one result per `MU_LAT`+1 cycles.
- `busy` rises the cycle after accept and falls the cycle after the final handshake or flush.
- `req_ready` is combinational from state, `rsp_ready` and `flush`. All other outputs are registered.

## Test plan
- Reset mid-WAIT, then release: all outputs at reset values, `req_ready`=1, no `rsp_valid` afterwards.
- MUL a=3, b=4, mulctl=00, `MU_LAT`=4, `rsp_ready`=1: `rsp_valid` exactly 5 cycles after accept with `rsp_data`=12 and `rsp_rd`=req tag; `mu_a/mu_b` stable throughout WAIT.
- a=b=0xFFFFFFFF under each mulctl: MUL→0x00000001, MULH→0x00000000, MULHSU→0xFFFFFFFF, MULHU→0xFFFFFFFE.
- `rsp_ready` held low 3 cycles in DONE with a new request pending: `rsp_valid`/`rsp_data` stable and `req_ready`=0. When `rsp_ready` rises, handshake and new accept happen on the same edge, and the second result follows 5 cycles later.
- `flush` during WAIT cycle 2: no `rsp_valid` ever for that request, `busy`=0 next cycle, and the next request completes normally.
- `flush` and `req_valid` asserted together in IDLE: `req_ready`=0, the request is not accepted, and the state stays IDLE.
